// File: rtl/line_clear_engine_pkg.sv
// Shared definitions for the line-clear engine: board geometry, colours, FSM states.
// The FL_* states only exist when CLEAR_FLASH_EN is defined.
package line_clear_engine_pkg;

  localparam int ROWS         = 20;
  localparam int COLS         = 10;
  localparam int COLOR_W      = 24;
  localparam int ROW_W        = 5;
  localparam int FLASH_FRAMES = 8;

  localparam logic [COLOR_W-1:0] EMPTY_COLOR = 24'h000000;
  localparam logic [COLOR_W-1:0] MINTY       = 24'h98FF98;
  localparam logic [COLOR_W-1:0] BLUE        = 24'h0000FF;
  localparam logic [COLOR_W-1:0] PINK        = 24'hFF69B4;
  localparam logic [COLOR_W-1:0] ORANGE      = 24'hFFA500;
  localparam logic [COLOR_W-1:0] YELLOW      = 24'hFFFF00;
  localparam logic [COLOR_W-1:0] PLUM        = 24'hDDA0DD;
  localparam logic [COLOR_W-1:0] LIGHT_GREY  = 24'hD3D3D3;

  typedef enum logic [3:0] {
    IDLE,
    SC_ADDR,
    SC_WAIT,
    SC_EVAL,
`ifdef CLEAR_FLASH_EN
    FL_WR,
    FL_WAIT,
`endif
    CP_ADDR,
    CP_WAIT,
    CP_WR,
    FILL,
    DONE
  } lce_state_t;

  function automatic logic [4:0] popcount(input logic [ROWS-1:0] mask);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++) n = n + 5'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/row_full_check.sv
// Combinational full-row detector: high when no cell of the row holds EMPTY_COLOR.
module row_full_check
  import line_clear_engine_pkg::*;
(
  input  logic [COLS*COLOR_W-1:0] row,
  output logic                    full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (row[c*COLOR_W +: COLOR_W] == EMPTY_COLOR) full = 1'b0;
  end

endmodule

// File: rtl/line_clear_engine.sv
// Scans the board for full rows, compacts the board downward and refills the top.
// Optional CLEAR_FLASH_EN paints full rows LIGHT_GREY and waits FLASH_FRAMES frames first.
module line_clear_engine
  import line_clear_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    frame_tick,
  output logic [ROW_W-1:0]        ram_row,
  output logic [COLS-1:0]         ram_we,
  output logic [COLS*COLOR_W-1:0] ram_d,
  input  logic [COLS*COLOR_W-1:0] ram_q,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              lines,
  output logic [9:0]              lines_total
);

  localparam logic [ROW_W:0] LAST_ROW = (ROW_W+1)'(ROWS-1);

  lce_state_t       state, state_nxt;
  logic [ROW_W:0]   rd, wr, rd_nxt, wr_nxt;
  logic [ROWS-1:0]  full_mask, mask_nxt;
  logic             row_full;
  logic [4:0]       line_count;
  logic [10:0]      total_sum;

`ifdef CLEAR_FLASH_EN
  logic [ROWS-1:0]  flash_left, flash_nxt;
  logic [ROW_W-1:0] flash_row;
  logic [3:0]       frame_cnt;
`else
  logic             unused_frame_tick;
  assign unused_frame_tick = frame_tick;
`endif

  row_full_check u_row_full_check (
    .row  (ram_q),
    .full (row_full)
  );

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign line_count = popcount(mask_nxt);
  assign total_sum  = 11'(lines_total) + 11'(line_count);

`ifdef CLEAR_FLASH_EN
  always_comb begin
    flash_row = '0;
    for (int r = ROWS-1; r >= 0; r--)
      if (flash_left[r]) flash_row = ROW_W'(r);
  end
`endif

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd;
    wr_nxt    = wr;
    mask_nxt  = full_mask;
    ram_row   = '0;
    ram_we    = '0;
    ram_d     = '0;
`ifdef CLEAR_FLASH_EN
    flash_nxt = flash_left;
`endif
    case (state)
      IDLE: if (start) begin
        state_nxt = SC_ADDR;
        rd_nxt    = LAST_ROW;
        mask_nxt  = '0;
      end
      SC_ADDR: begin
        ram_row   = rd[ROW_W-1:0];
        state_nxt = SC_WAIT;
      end
      SC_WAIT: begin
        ram_row   = rd[ROW_W-1:0];
        state_nxt = SC_EVAL;
      end
      SC_EVAL: begin
        ram_row = rd[ROW_W-1:0];
        mask_nxt[rd[ROW_W-1:0]] = row_full;
        if (rd == '0) begin
          rd_nxt = LAST_ROW;
          wr_nxt = LAST_ROW;
          if (mask_nxt == '0) state_nxt = DONE;
          else begin
`ifdef CLEAR_FLASH_EN
            flash_nxt = mask_nxt;
            state_nxt = FL_WR;
`else
            state_nxt = CP_ADDR;
`endif
          end
        end else begin
          rd_nxt    = rd - 1'b1;
          state_nxt = SC_ADDR;
        end
      end
`ifdef CLEAR_FLASH_EN
      FL_WR: begin
        ram_row   = flash_row;
        ram_we    = '1;
        ram_d     = {COLS{LIGHT_GREY}};
        flash_nxt = flash_left & ~(ROWS'(1) << flash_row);
        if (flash_nxt == '0) state_nxt = FL_WAIT;
      end
      FL_WAIT:
        if (frame_tick && frame_cnt == 4'(FLASH_FRAMES-1)) state_nxt = CP_ADDR;
`endif
      // Full rows and in-place rows cost one cycle; only displaced rows are copied.
      CP_ADDR: begin
        if (full_mask[rd[ROW_W-1:0]] || rd == wr) begin
          rd_nxt = rd - 1'b1;
          if (!full_mask[rd[ROW_W-1:0]]) wr_nxt = wr - 1'b1;
          if (rd == '0) state_nxt = wr_nxt[ROW_W] ? DONE : FILL;
        end else begin
          ram_row   = rd[ROW_W-1:0];
          state_nxt = CP_WAIT;
        end
      end
      CP_WAIT: begin
        ram_row   = rd[ROW_W-1:0];
        state_nxt = CP_WR;
      end
      CP_WR: begin
        ram_row = wr[ROW_W-1:0];
        ram_we  = '1;
        ram_d   = ram_q;
        rd_nxt  = rd - 1'b1;
        wr_nxt  = wr - 1'b1;
        if (rd == '0) state_nxt = wr_nxt[ROW_W] ? DONE : FILL;
        else          state_nxt = CP_ADDR;
      end
      FILL: begin
        ram_row = wr[ROW_W-1:0];
        ram_we  = '1;
        ram_d   = {COLS{EMPTY_COLOR}};
        wr_nxt  = wr - 1'b1;
        if (wr == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers update on entry to DONE so they are valid during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd          <= '0;
      wr          <= '0;
      full_mask   <= '0;
      lines       <= '0;
      lines_total <= '0;
`ifdef CLEAR_FLASH_EN
      flash_left  <= '0;
      frame_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      rd        <= rd_nxt;
      wr        <= wr_nxt;
      full_mask <= mask_nxt;
      if (state_nxt == DONE && state != DONE) begin
        lines       <= line_count[2:0];
        lines_total <= (total_sum > 11'd1023) ? 10'd1023 : total_sum[9:0];
      end
`ifdef CLEAR_FLASH_EN
      flash_left <= flash_nxt;
      if (state == FL_WR)                      frame_cnt <= '0;
      else if (state == FL_WAIT && frame_tick) frame_cnt <= frame_cnt + 1'b1;
`endif
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) (state == DONE) |-> (line_count <= 5'd4));

endmodule
